// File: rtl/record_seq_ctrl_if.sv
// Bus bundle between the control/register layer and the record sequencer.
interface record_seq_ctrl_if #(
    parameter int unsigned CTR_WIDTH    = 24,
    parameter int unsigned PERIOD_WIDTH = 16
);
    logic                    i_ce;
    logic                    i_start;
    logic                    i_abort;
    logic [CTR_WIDTH-1:0]    i_rec_len;
    logic [PERIOD_WIDTH-1:0] i_period;
    logic                    i_sample_valid;
    logic                    o_sample_req;
    logic                    o_new_record;
    logic [CTR_WIDTH-1:0]    o_sample_ctr;
    logic                    o_busy;
    logic                    o_done;
    logic                    o_timeout;

    // Controller / sample-source side
    modport master (
        output i_ce, i_start, i_abort, i_rec_len, i_period, i_sample_valid,
        input  o_sample_req, o_new_record, o_sample_ctr, o_busy, o_done, o_timeout
    );

    // Sequencer side
    modport slave (
        input  i_ce, i_start, i_abort, i_rec_len, i_period, i_sample_valid,
        output o_sample_req, o_new_record, o_sample_ctr, o_busy, o_done, o_timeout
    );
endinterface

// File: rtl/record_seq_ctrl.sv
// Record sequencer: opens a record, paces sample requests, times out stalled
// handshakes, counts accepted samples and closes the record at the set length.
module record_seq_ctrl #(
    parameter int unsigned CTR_WIDTH    = 24,
    parameter int unsigned PERIOD_WIDTH = 16,
    parameter int unsigned TIMEOUT      = 1023
) (
    input  logic               i_clk,
    input  logic               i_nrst,
    record_seq_ctrl_if.slave   bus
);

    localparam int unsigned TMR_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_REQ   = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]              state_q, state_d;
    logic [CTR_WIDTH-1:0]    ctr_q, ctr_d;
    logic [CTR_WIDTH-1:0]    len_q, len_d;
    logic [CTR_WIDTH-1:0]    ctr_inc;
    logic [PERIOD_WIDTH-1:0] per_q, per_d;
    logic [PERIOD_WIDTH-1:0] p_q, p_d;
    logic [TMR_WIDTH-1:0]    t_q, t_d;
    logic                    tmo_q, tmo_d;

    // Next-state and register-update logic; abort overrides everything outside IDLE
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        len_d   = len_q;
        per_d   = per_q;
        t_d     = t_q;
        tmo_d   = tmo_q;
        ctr_inc = ctr_q + CTR_WIDTH'(1);

        // Period timer reloads in REQ, otherwise counts down to zero
        if (state_q == S_REQ) begin
            p_d = (per_q == '0) ? '0 : per_q - PERIOD_WIDTH'(1);
        end else begin
            p_d = (p_q == '0) ? '0 : p_q - PERIOD_WIDTH'(1);
        end

        if (bus.i_abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.i_start) begin
                        len_d   = bus.i_rec_len;
                        per_d   = bus.i_period;
                        tmo_d   = 1'b0;
                        state_d = (bus.i_rec_len == '0) ? S_DONE : S_START;
                    end
                end
                S_START: begin
                    ctr_d   = '0;
                    state_d = S_REQ;
                end
                S_REQ: begin
                    t_d     = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (bus.i_sample_valid) begin
                        ctr_d   = ctr_inc;
                        state_d = (ctr_inc == len_q) ? S_DONE : S_GAP;
                    end else if (t_q == TMR_WIDTH'(TIMEOUT - 1)) begin
                        tmo_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        t_d = t_q + TMR_WIDTH'(1);
                    end
                end
                S_GAP: begin
                    if (p_q <= PERIOD_WIDTH'(1)) begin
                        state_d = S_REQ;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers, frozen while the clock enable is low
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= S_IDLE;
            ctr_q   <= '0;
            len_q   <= '0;
            per_q   <= '0;
            p_q     <= '0;
            t_q     <= '0;
            tmo_q   <= 1'b0;
        end else if (bus.i_ce) begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            len_q   <= len_d;
            per_q   <= per_d;
            p_q     <= p_d;
            t_q     <= t_d;
            tmo_q   <= tmo_d;
        end
    end

    // Pulses are state decodes qualified by the enable so they never stretch
    assign bus.o_sample_req = (state_q == S_REQ)   & bus.i_ce;
    assign bus.o_new_record = (state_q == S_START) & bus.i_ce;
    assign bus.o_done       = (state_q == S_DONE)  & bus.i_ce;
    assign bus.o_busy       = (state_q != S_IDLE);
    assign bus.o_sample_ctr = ctr_q;
    assign bus.o_timeout    = tmo_q;

endmodule

// File: tb/tb_record_seq_ctrl.sv
// Scoreboard bench for record_seq_ctrl: expected pulse events are queued by
// the stimulus, a negedge monitor pops and compares every pulse the DUT emits.
module tb_record_seq_ctrl;

    localparam int unsigned CW = 24;
    localparam int unsigned PW = 16;
    localparam int unsigned TO = 8;

    localparam int EV_NR   = 0;
    localparam int EV_REQ  = 1;
    localparam int EV_DONE = 2;

    typedef struct {
        int kind;
        int cyc;
        int ctr;
        int tmo;
    } ev_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    ev_t  exp_q[$];

    record_seq_ctrl_if #(.CTR_WIDTH(CW), .PERIOD_WIDTH(PW)) bus ();

    record_seq_ctrl #(
        .CTR_WIDTH   (CW),
        .PERIOD_WIDTH(PW),
        .TIMEOUT     (TO)
    ) dut (
        .i_clk (clk),
        .i_nrst(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint got, input longint exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
        end
    endtask

    task automatic push(input int kind, input int c, input int ctr, input int tmo);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.ctr  = ctr;
        e.tmo  = tmo;
        exp_q.push_back(e);
    endtask

    task automatic handle(input int kind);
        ev_t e;
        int  ctr_now;
        int  tmo_now;
        ctr_now = int'(bus.o_sample_ctr);
        tmo_now = int'(bus.o_timeout);
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: got kind=%0d at cycle %0d, expected none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc ||
                (kind == EV_DONE && (e.ctr != ctr_now || e.tmo != tmo_now))) begin
                miscompares++;
                $display("FAIL event: got kind=%0d cyc=%0d ctr=%0d tmo=%0d, expected kind=%0d cyc=%0d ctr=%0d tmo=%0d",
                         kind, cyc, ctr_now, tmo_now, e.kind, e.cyc, e.ctr, e.tmo);
            end
        end
    endtask

    // Monitor: every pulse the DUT presents is matched against the scoreboard
    always @(negedge clk) begin
        if (bus.o_new_record) handle(EV_NR);
        if (bus.o_sample_req) handle(EV_REQ);
        if (bus.o_done)       handle(EV_DONE);
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_rec(input int len, input int per);
        int c0;
        c0 = cyc;
        bus.i_rec_len = CW'(len);
        bus.i_period  = PW'(per);
        bus.i_start   = 1'b1;
        goto(c0 + 1);
        bus.i_start   = 1'b0;
    endtask

    task automatic pulse_valid(input int c);
        goto(c);
        bus.i_sample_valid = 1'b1;
        goto(c + 1);
        bus.i_sample_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s;
        rst_n              = 1'b0;
        bus.i_ce           = 1'b1;
        bus.i_start        = 1'b0;
        bus.i_abort        = 1'b0;
        bus.i_rec_len      = '0;
        bus.i_period       = '0;
        bus.i_sample_valid = 1'b0;

        // Reset state
        goto(3);
        check("rst_busy",    bus.o_busy,       0);
        check("rst_ctr",     bus.o_sample_ctr, 0);
        check("rst_timeout", bus.o_timeout,    0);
        check("rst_req",     bus.o_sample_req, 0);
        check("rst_nr",      bus.o_new_record, 0);
        check("rst_done",    bus.o_done,       0);
        rst_n = 1'b1;
        goto(5);

        // T1: len=3, P=4, valid one cycle after each request
        s = cyc;
        push(EV_NR,   s + 1,  0, 0);
        push(EV_REQ,  s + 2,  0, 0);
        push(EV_REQ,  s + 6,  0, 0);
        push(EV_REQ,  s + 10, 0, 0);
        push(EV_DONE, s + 12, 3, 0);
        start_rec(3, 4);
        pulse_valid(s + 3);
        pulse_valid(s + 7);
        pulse_valid(s + 11);
        goto(s + 14);
        check("t1_busy",    bus.o_busy,       0);
        check("t1_ctr",     bus.o_sample_ctr, 3);
        check("t1_timeout", bus.o_timeout,    0);

        // T2: len=2, P=2, valid five cycles after request -> spacing 7
        s = cyc;
        push(EV_NR,   s + 1,  0, 0);
        push(EV_REQ,  s + 2,  0, 0);
        push(EV_REQ,  s + 9,  0, 0);
        push(EV_DONE, s + 15, 2, 0);
        start_rec(2, 2);
        pulse_valid(s + 7);
        pulse_valid(s + 14);
        goto(s + 17);
        check("t2_busy", bus.o_busy,       0);
        check("t2_ctr",  bus.o_sample_ctr, 2);

        // T3: len=4, no valid -> timeout 9 cycles after first request
        s = cyc;
        push(EV_NR,   s + 1,  0, 0);
        push(EV_REQ,  s + 2,  0, 0);
        push(EV_DONE, s + 11, 0, 1);
        start_rec(4, 4);
        goto(s + 7);
        check("t3_busy_mid", bus.o_busy,       1);
        check("t3_ctr_mid",  bus.o_sample_ctr, 0);
        goto(s + 13);
        check("t3_timeout", bus.o_timeout, 1);
        check("t3_busy",    bus.o_busy,    0);

        // T4: len=5, P=3, abort after the second valid
        s = cyc;
        push(EV_NR,  s + 1, 0, 0);
        push(EV_REQ, s + 2, 0, 0);
        push(EV_REQ, s + 5, 0, 0);
        start_rec(5, 3);
        check("t4_timeout_cleared", bus.o_timeout, 0);
        pulse_valid(s + 3);
        pulse_valid(s + 6);
        goto(s + 7);
        check("t4_ctr_pre_abort", bus.o_sample_ctr, 2);
        bus.i_abort = 1'b1;
        goto(s + 8);
        bus.i_abort = 1'b0;
        check("t4_busy", bus.o_busy,       0);
        check("t4_ctr",  bus.o_sample_ctr, 2);
        goto(s + 18);
        check("t4_ctr_hold", bus.o_sample_ctr, 2);

        // T5a: len=1; start and config changes while busy, valid outside WAIT
        s = cyc;
        push(EV_NR,   s + 1, 0, 0);
        push(EV_REQ,  s + 2, 0, 0);
        push(EV_DONE, s + 4, 1, 0);
        bus.i_rec_len = CW'(1);
        bus.i_period  = PW'(3);
        bus.i_start   = 1'b1;
        goto(s + 1);
        bus.i_start        = 1'b0;
        bus.i_sample_valid = 1'b1;
        goto(s + 2);
        bus.i_start   = 1'b1;
        bus.i_rec_len = CW'(7);
        goto(s + 4);
        bus.i_start        = 1'b0;
        bus.i_sample_valid = 1'b0;
        goto(s + 6);
        check("t5_ctr",  bus.o_sample_ctr, 1);
        check("t5_busy", bus.o_busy,       0);

        // T5b: len=0 -> done one cycle after start, no request or new record
        s = cyc;
        push(EV_DONE, s + 1, 1, 0);
        start_rec(0, 5);
        goto(s + 3);
        check("t5_len0_busy", bus.o_busy,       0);
        check("t5_len0_ctr",  bus.o_sample_ctr, 1);

        // T6: enable low for three cycles in GAP, then reset during WAIT
        s = cyc;
        push(EV_NR,  s + 1, 0, 0);
        push(EV_REQ, s + 2, 0, 0);
        push(EV_REQ, s + 9, 0, 0);
        start_rec(2, 4);
        pulse_valid(s + 3);
        bus.i_ce = 1'b0;
        goto(s + 5);
        check("t6_busy_ce_low", bus.o_busy, 1);
        goto(s + 7);
        bus.i_ce = 1'b1;
        goto(s + 10);
        check("t6_busy_wait", bus.o_busy,       1);
        check("t6_ctr_wait",  bus.o_sample_ctr, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy",    bus.o_busy,       0);
        check("t6_rst_ctr",     bus.o_sample_ctr, 0);
        check("t6_rst_timeout", bus.o_timeout,    0);
        check("t6_rst_req",     bus.o_sample_req, 0);
        check("t6_rst_nr",      bus.o_new_record, 0);
        check("t6_rst_done",    bus.o_done,       0);
        goto(s + 12);
        rst_n = 1'b1;
        goto(s + 16);
        check("t6_post_rst_busy", bus.o_busy, 0);

        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
